single_port_ram_arbiter: RTL
============================

// Module: single_port_ram_arbiter
// PURPOSE
// - Shares one single_port_ram between two independent requesters (A=0, B=1), each with a valid/ready request channel.
// - Requests can be reads or writes. Exactly one RAM access is granted per cycle.
// - Read responses are registered and returned on a per-requester response channel one cycle after the grant.
// - Sits between two bus-side agents (e.g. a DMA and a CPU port) and the shared storage array.
// PARAMETERS
// - WIDTH          8             data word width in bits
// - DEPTH          16            number of words in the RAM
// - ADDRESS_WIDTH  CLOG2(DEPTH)  address width
// - ROUND_ROBIN    1             1: round-robin arbitration; 0: fixed priority, A always wins
// PORTS
// - clock                 in   1              single clock, all state on rising edge
// - resetn                in   1              asynchronous, active-low reset
// - a_request_valid       in   1              requester A presents a request
// - a_request_ready       out  1              A's request is granted this cycle
// - a_request_write       in   1              1: write, 0: read
// - a_request_address     in   ADDRESS_WIDTH  word address
// - a_request_write_data  in   WIDTH          write data, ignored for reads
// - a_response_valid      out  1              one-cycle pulse: A's read data is available
// - a_response_data       out  WIDTH          read data for A
// - b_*                   same set of ports and meanings for requester B
// BEHAVIOUR
// - Reset values (asynchronous, while resetn=0):
//   - all *_request_ready = 0 (combinational, forced low during reset)
//   - *_response_valid = 0, *_response_data = 0
//   - priority pointer = A
//   - RAM contents = 0 (cleared by the RAM's own reset)
// - Grant (combinational, same cycle as the request):
//   - only one of a_ or b_request_ready is high in any cycle
//   - ready is never asserted without the matching valid
//   - a transfer occurs when valid && ready at a rising edge
// - Round-robin (ROUND_ROBIN=1):
//   - only one requester valid: it is granted immediately
//   - both valid: the pointer's requester wins
//   - after any granted transfer, the pointer moves to the other requester
//   - no grant, pointer unchanged
//   - consequence: back-to-back contention alternates A,B,A,B; neither requester waits more than 1 cycle
// - Fixed priority (ROUND_ROBIN=0): A wins every contention; the pointer is unused. B may starve; this is by design.
// - Write grant: RAM write_enable=1 and memory[address] is updated at that edge. No response is generated for writes.
// - Read grant: RAM read_enable=1. RAM read data (combinational) is captured into the granted requester's response_data register.
//   - that requester's response_valid=1 for exactly the next cycle
//   - latency is 1 cycle from grant edge to response
//   - responses have no backpressure; the requester must accept
// - response_data holds its last captured value until that requester's next read; the other requester's response register is untouched.
// - Ordering: accesses take effect in grant order.
//   - a write granted at cycle N is visible to a read granted at N+1 or later, for either requester
//   - same-address conflicts in one cycle are impossible (single grant)
// - Request fields are sampled only on the grant cycle. A requester may change or drop valid at any time before it is granted; no stickiness is required.
// - Reset mid-operation:
//   - a pending response is discarded; response_valid stays 0 after reset release
//   - the pointer returns to A
// - The address is not range-checked. For DEPTH not a power of two, out-of-range addresses are a caller error.
// STRUCTURE
// - Shared header common.vh provides the CLOG2 macro.
// - Localparams REQUESTER_A=0 and REQUESTER_B=1 are defined locally.
// - Sub-module: instantiate single_port_ram unchanged for the array.
// - The arbiter (grant, pointer) and the two response registers live in this module. No further split is warranted.
// TESTING
// - Reset, then idle: all ready=0, response_valid=0, response_data=0.
// - Single requester: A writes 0xA5 @3, then reads @3 -> a_response_valid pulses 1 cycle after the read grant with a_response_data=0xA5; B outputs unchanged.
// - Contention, round-robin: both valid for 4 cycles (A reads @1, B reads @2, preloaded 0x11/0x22) -> grants A,B,A,B; responses alternate 0x11, 0x22.
// - Cross-requester ordering: A writes 0x5C @7 at cycle N; B reads @7 at N+1 -> b_response_data=0x5C.
// - ROUND_ROBIN=0: both valid continuously -> A granted every cycle, b_request_ready stays 0; B is granted on the first cycle A drops valid.
// - Reset asserted in the cycle after a read grant: response_valid=0, RAM reads back 0 @3, first post-reset contention grants A.

Source files
------------

// File: rtl/single_port_ram_arbiter_pkg.sv
// Shared types and helpers for the two-requester single-port RAM arbiter.
package single_port_ram_arbiter_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2
  } grant_e;

  // The round-robin pointer always hands priority to whoever was not just served.
  function automatic logic other_requester(input logic requester);
    return ~requester;
  endfunction

endpackage

// File: rtl/single_port_ram_arbiter_ram.sv
// Single-port storage array: synchronous write, combinational read, cleared by reset.
module single_port_ram #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     write_enable,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]         write_data,
  output logic [WIDTH-1:0]         read_data
);

  logic [WIDTH-1:0] memory_q [DEPTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory_q[i] <= '0;
      end
    end else if (write_enable) begin
      memory_q[address] <= write_data;
    end
  end

  assign read_data = read_enable ? memory_q[address] : '0;

endmodule

// File: rtl/single_port_ram_arbiter.sv
// Arbitrates two valid/ready requesters onto one single-port RAM and returns
// registered read responses one cycle after the grant.
module single_port_ram_arbiter
  import single_port_ram_arbiter_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int ROUND_ROBIN   = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     a_request_valid,
  output logic                     a_request_ready,
  input  logic                     a_request_write,
  input  logic [ADDRESS_WIDTH-1:0] a_request_address,
  input  logic [WIDTH-1:0]         a_request_write_data,
  output logic                     a_response_valid,
  output logic [WIDTH-1:0]         a_response_data,
  input  logic                     b_request_valid,
  output logic                     b_request_ready,
  input  logic                     b_request_write,
  input  logic [ADDRESS_WIDTH-1:0] b_request_address,
  input  logic [WIDTH-1:0]         b_request_write_data,
  output logic                     b_response_valid,
  output logic [WIDTH-1:0]         b_response_data
);

  localparam logic REQUESTER_A = 1'b0;
  localparam logic REQUESTER_B = 1'b1;

  grant_e                   grant;
  logic                     ptr_q, ptr_d;
  logic                     a_rsp_valid_q, a_rsp_valid_d;
  logic                     b_rsp_valid_q, b_rsp_valid_d;
  logic [WIDTH-1:0]         a_rsp_data_q, a_rsp_data_d;
  logic [WIDTH-1:0]         b_rsp_data_q, b_rsp_data_d;
  logic                     ram_we, ram_re;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [WIDTH-1:0]         ram_wdata, ram_rdata;

  // Grants are suppressed during reset so ready is low while resetn is low.
  always_comb begin
    grant = GRANT_NONE;
    if (resetn) begin
      if (a_request_valid && b_request_valid) begin
        grant = (ROUND_ROBIN != 0 && ptr_q == REQUESTER_B) ? GRANT_B : GRANT_A;
      end else if (a_request_valid) begin
        grant = GRANT_A;
      end else if (b_request_valid) begin
        grant = GRANT_B;
      end
    end
  end

  assign a_request_ready = (grant == GRANT_A);
  assign b_request_ready = (grant == GRANT_B);

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = a_request_address;
    ram_wdata = a_request_write_data;
    if (grant == GRANT_A) begin
      ram_we = a_request_write;
      ram_re = ~a_request_write;
    end else if (grant == GRANT_B) begin
      ram_addr  = b_request_address;
      ram_wdata = b_request_write_data;
      ram_we    = b_request_write;
      ram_re    = ~b_request_write;
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_data_d  = a_rsp_data_q;
    b_rsp_data_d  = b_rsp_data_q;
    if (ROUND_ROBIN != 0 && grant != GRANT_NONE) begin
      ptr_d = other_requester((grant == GRANT_A) ? REQUESTER_A : REQUESTER_B);
    end
    if (grant == GRANT_A && ram_re) begin
      a_rsp_valid_d = 1'b1;
      a_rsp_data_d  = ram_rdata;
    end
    if (grant == GRANT_B && ram_re) begin
      b_rsp_valid_d = 1'b1;
      b_rsp_data_d  = ram_rdata;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q         <= REQUESTER_A;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
    end else begin
      ptr_q         <= ptr_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
    end
  end

  assign a_response_valid = a_rsp_valid_q;
  assign a_response_data  = a_rsp_data_q;
  assign b_response_valid = b_rsp_valid_q;
  assign b_response_data  = b_rsp_data_q;

  single_port_ram #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clock       (clock),
    .resetn      (resetn),
    .write_enable(ram_we),
    .read_enable (ram_re),
    .address     (ram_addr),
    .write_data  (ram_wdata),
    .read_data   (ram_rdata)
  );

endmodule
